// File: rtl/block_ram_dp_if.sv
// block_ram_dp_if: write/read bus of the simple dual-port block RAM
interface block_ram_dp_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 128
);
   logic                    w_e;
   logic [0:ADDR_WIDTH-1]   w_addr;
   logic [0:DATA_WIDTH-1]   w_data;
   logic [0:DATA_WIDTH/8-1] w_strb;
   logic                    r_e;
   logic [0:ADDR_WIDTH-1]   r_addr;
   logic [0:DATA_WIDTH-1]   o_data;
   logic                    o_valid;
   modport master (output w_e, w_addr, w_data, w_strb, r_e, r_addr, input o_data, o_valid);
   modport slave (input w_e, w_addr, w_data, w_strb, r_e, r_addr, output o_data, o_valid);
endinterface

// File: rtl/block_ram_dp.sv
// block_ram_dp: simple dual-port block RAM with byte strobes, 1/2-cycle read latency and read-during-write policy
module block_ram_dp #(
   parameter int ADDR_WIDTH   = 9,
   parameter int DATA_WIDTH   = 128,
   parameter int DEPTH        = 512,
   parameter int READ_LATENCY = 1,
   parameter int RDW_MODE     = 0
) (
   input logic           clk,
   input logic           reset,
   block_ram_dp_if.slave bus
);
   localparam int NB = DATA_WIDTH / 8;
   logic [0:DATA_WIDTH-1] mem [DEPTH];
   logic [0:DATA_WIDTH-1] rd_word;
   logic [0:DATA_WIDTH-1] s1_data;
   logic                  s1_valid;
   logic                  w_ok;
   logic                  r_ok;
   logic                  hit;
   assign w_ok = bus.w_e && ({1'b0, bus.w_addr} < (ADDR_WIDTH+1)'(DEPTH));
   assign r_ok = {1'b0, bus.r_addr} < (ADDR_WIDTH+1)'(DEPTH);
   assign hit  = (RDW_MODE == 1) && w_ok && r_ok && (bus.w_addr == bus.r_addr);
   // array read; out-of-range reads return zero, and new-data policy merges the strobed lanes of a same-address write
   always_comb begin
      rd_word = r_ok ? mem[bus.r_addr] : '0;
      for (int k = 0; k < NB; k++)
         if (hit && bus.w_strb[k]) rd_word[8*k +: 8] = bus.w_data[8*k +: 8];
   end
   // byte-lane write; out-of-range addresses never touch the array
   always_ff @(posedge clk)
      for (int k = 0; k < NB; k++)
         if (w_ok && bus.w_strb[k]) mem[bus.w_addr][8*k +: 8] <= bus.w_data[8*k +: 8];
   // stage 1: array read register with its valid bit; data only moves on an accepted read
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= bus.r_e;
         if (bus.r_e) s1_data <= rd_word;
      end
   if (READ_LATENCY == 2) begin : g_l2
      logic [0:DATA_WIDTH-1] o_q;
      logic                  v_q;
      // stage 2: output register, updated only when stage 1 carries a result
      always_ff @(posedge clk or posedge reset)
         if (reset) begin
            v_q <= 1'b0;
            o_q <= '0;
         end else begin
            v_q <= s1_valid;
            if (s1_valid) o_q <= s1_data;
         end
      assign bus.o_data  = o_q;
      assign bus.o_valid = v_q;
   end else begin : g_l1
      assign bus.o_data  = s1_data;
      assign bus.o_valid = s1_valid;
   end
endmodule

// File: tb/tb_block_ram_dp.sv
// tb_block_ram_dp: three RAM configurations driven with identical stimulus and checked against a behavioural model
module tb_block_ram_dp;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         w_e, r_e;
   logic [0:8]   w_addr, r_addr;
   logic [0:127] w_data;
   logic [0:15]  w_strb;
   logic [0:127] od [3];
   logic         ov [3];
   int           checks = 0, failures = 0;

   function automatic int lat(input int i); return i == 0 ? 1 : 2; endfunction
   function automatic bit rdw(input int i); return i == 1; endfunction
   function automatic int dep(input int i); return i == 2 ? 500 : 512; endfunction
   function automatic logic [0:127] mrg(input logic [0:127] o, input logic [0:127] d, input logic [0:15] s);
      for (int k = 0; k < 16; k++) if (s[k]) o[8*k +: 8] = d[8*k +: 8];
      return o;
   endfunction

   always #5 clk = ~clk;

   block_ram_dp_if #(.ADDR_WIDTH(9), .DATA_WIDTH(128)) bus0 (), bus1 (), bus2 ();
   assign {bus0.w_e, bus1.w_e, bus2.w_e} = {3{w_e}};
   assign {bus0.r_e, bus1.r_e, bus2.r_e} = {3{r_e}};
   assign {bus0.w_addr, bus1.w_addr, bus2.w_addr} = {3{w_addr}};
   assign {bus0.r_addr, bus1.r_addr, bus2.r_addr} = {3{r_addr}};
   assign {bus0.w_data, bus1.w_data, bus2.w_data} = {3{w_data}};
   assign {bus0.w_strb, bus1.w_strb, bus2.w_strb} = {3{w_strb}};
   assign od[0] = bus0.o_data;
   assign od[1] = bus1.o_data;
   assign od[2] = bus2.o_data;
   assign ov[0] = bus0.o_valid;
   assign ov[1] = bus1.o_valid;
   assign ov[2] = bus2.o_valid;

   block_ram_dp #(.ADDR_WIDTH(9), .DATA_WIDTH(128), .DEPTH(512), .READ_LATENCY(1), .RDW_MODE(0))
      u0 (.clk(clk), .reset(reset), .bus(bus0));
   block_ram_dp #(.ADDR_WIDTH(9), .DATA_WIDTH(128), .DEPTH(512), .READ_LATENCY(2), .RDW_MODE(1))
      u1 (.clk(clk), .reset(reset), .bus(bus1));
   block_ram_dp #(.ADDR_WIDTH(9), .DATA_WIDTH(128), .DEPTH(500), .READ_LATENCY(2), .RDW_MODE(0))
      u2 (.clk(clk), .reset(reset), .bus(bus2));

   // behavioural model: word array per configuration plus a timing wheel of results keyed by due cycle
   logic [0:127] mm [3][512];
   logic [0:127] wd [3][8];
   logic         wv [3][8];
   logic [0:127] ed [3];
   logic         ev [3];
   logic [0:127] rd;
   int           cyc = 0, sl, now;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            ev[i] = 1'b0;
            ed[i] = '0;
            for (int s = 0; s < 8; s++) wv[i][s] = 1'b0;
         end
      end else begin
         cyc++;
         now = cyc % 8;
         for (int i = 0; i < 3; i++) begin
            if (r_e) begin
               rd = int'(r_addr) < dep(i) ? mm[i][r_addr] : '0;
               if (rdw(i) && w_e && w_addr == r_addr && int'(r_addr) < dep(i)) rd = mrg(rd, w_data, w_strb);
               sl = (cyc + lat(i) - 1) % 8;
               wv[i][sl] = 1'b1;
               wd[i][sl] = rd;
            end
            ev[i] = wv[i][now];
            if (wv[i][now]) ed[i] = wd[i][now];
            wv[i][now] = 1'b0;
            if (w_e && int'(w_addr) < dep(i)) mm[i][w_addr] = mrg(mm[i][w_addr], w_data, w_strb);
         end
      end
   end

   task automatic drv(input logic we, input int wa, input logic [0:127] wdt, input logic [0:15] ws,
                      input logic re, input int ra);
      w_e = we;
      w_addr = 9'(wa);
      w_data = wdt;
      w_strb = ws;
      r_e = re;
      r_addr = 9'(ra);
   endtask

   task automatic test_reset;
      logic [0:127] v;
      logic x;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (ov[i] !== 1'b0 || od[i] !== '0) begin
               failures++;
               $display("FAIL reset_hold inst%0d valid=%b data=%h required valid=0 data=0", i, ov[i], od[i]);
            end
         end
         drv(1'b0, 0, '0, '0, (c % 2) == 0, int'($urandom_range(511)));
      end
      reset = 1'b0;
      v = {$urandom, $urandom, $urandom, $urandom};
      drv(1'b1, 3, v, 16'hFFFF, 1'b0, 0);
      @(negedge clk);
      drv(1'b0, 0, '0, '0, 1'b1, 3);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         drv(1'b0, 0, '0, '0, 1'b0, 0);
         for (int i = 0; i < 3; i++) begin
            x = (k == lat(i));
            checks++;
            if (ov[i] !== x || (x && od[i] !== v)) begin
               failures++;
               $display("FAIL first_read inst%0d k=%0d valid=%b data=%h required valid=%b data=%h", i, k, ov[i], od[i], x, v);
            end
         end
      end
   endtask

   task automatic test_stream;
      for (int a = 0; a < 512; a++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (ov[i] !== ev[i] || od[i] !== ed[i]) begin
               failures++;
               $display("FAIL fill inst%0d valid=%b data=%h required valid=%b data=%h", i, ov[i], od[i], ev[i], ed[i]);
            end
         end
         drv(1'b1, a, 128'(a), 16'hFFFF, 1'b0, 0);
      end
      for (int t = 0; t < 515; t++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (ov[i] !== ev[i] || od[i] !== ed[i]) begin
               failures++;
               $display("FAIL stream inst%0d t=%0d valid=%b data=%h required valid=%b data=%h", i, t, ov[i], od[i], ev[i], ed[i]);
            end
         end
         if (t >= 2 && t < 514) begin
            checks++;
            if (ov[1] !== 1'b1 || od[1] !== 128'(t - 2)) begin
               failures++;
               $display("FAIL stream_order t=%0d valid=%b data=%h required valid=1 data=%h", t, ov[1], od[1], 128'(t - 2));
            end
         end
         drv(1'b0, 0, '0, '0, t < 512, t);
      end
   endtask

   task automatic test_strobe;
      logic [0:127] e1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      logic [0:127] e2 = 128'hFF112233_44556677_8899AABB_CCDDEEFF;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (ov[i] !== ev[i] || od[i] !== ed[i]) begin
               failures++;
               $display("FAIL strobe_model inst%0d valid=%b data=%h required valid=%b data=%h", i, ov[i], od[i], ev[i], ed[i]);
            end
         end
         if (c == 3 || c == 4 || c == 7 || c == 8) begin
            checks++;
            if (od[c % 2 == 1 ? 0 : 1] !== (c < 5 ? e1 : e2)) begin
               failures++;
               $display("FAIL strobe_merge c=%0d data=%h required=%h", c, od[c % 2 == 1 ? 0 : 1], c < 5 ? e1 : e2);
            end
         end
         case (c)
            0: drv(1'b1, 5, e1, 16'hFFFF, 1'b0, 0);
            1: drv(1'b1, 5, '1, 16'h0001, 1'b0, 0);
            5: drv(1'b1, 5, '1, 16'h8000, 1'b0, 0);
            2, 6: drv(1'b0, 0, '0, '0, 1'b1, 5);
            default: drv(1'b0, 0, '0, '0, 1'b0, 0);
         endcase
      end
   endtask

   task automatic test_collision;
      logic [0:127] aa = {16{8'hAA}};
      logic [0:127] ff = {16{8'h55}};
      logic [0:127] mx = {{8{8'hAA}}, {8{8'h55}}};
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (ov[i] !== ev[i] || od[i] !== ed[i]) begin
               failures++;
               $display("FAIL collision_model inst%0d valid=%b data=%h required valid=%b data=%h", i, ov[i], od[i], ev[i], ed[i]);
            end
         end
         if (c == 2 || c == 4) begin
            checks++;
            if (ov[0] !== 1'b1 || od[0] !== aa) begin
               failures++;
               $display("FAIL collision_old c=%0d data=%h required=%h", c, od[0], aa);
            end
         end
         if (c == 3 || c == 5) begin
            checks++;
            if (od[1] !== (c == 3 ? ff : mx) || od[2] !== aa) begin
               failures++;
               $display("FAIL collision_new c=%0d data=%h/%h required=%h/%h", c, od[1], od[2], c == 3 ? ff : mx, aa);
            end
         end
         case (c)
            0, 2: drv(1'b1, 7, aa, 16'hFFFF, 1'b0, 0);
            1: drv(1'b1, 7, ff, 16'hFFFF, 1'b1, 7);
            3: drv(1'b1, 7, ff, 16'h00FF, 1'b1, 7);
            default: drv(1'b0, 0, '0, '0, 1'b0, 0);
         endcase
      end
   endtask

   task automatic test_oor;
      logic [0:127] v = {$urandom, $urandom, $urandom, $urandom};
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (ov[i] !== ev[i] || od[i] !== ed[i]) begin
               failures++;
               $display("FAIL oor_model inst%0d valid=%b data=%h required valid=%b data=%h", i, ov[i], od[i], ev[i], ed[i]);
            end
         end
         if (c == 3) begin
            checks++;
            if (ov[2] !== 1'b1 || od[2] !== '0 || od[1] !== v) begin
               failures++;
               $display("FAIL oor_read valid=%b data=%h/%h required valid=1 data=0/%h", ov[2], od[2], od[1], v);
            end
         end
         if (c >= 4) begin
            checks++;
            if (ov[0] !== 1'b0 || ov[2] !== 1'b0 || od[0] !== v || od[2] !== '0) begin
               failures++;
               $display("FAIL hold c=%0d valid=%b/%b data=%h/%h required valid=0/0 data=%h/0", c, ov[0], ov[2], od[0], od[2], v);
            end
         end
         case (c)
            0: drv(1'b1, 505, v, 16'hFFFF, 1'b0, 0);
            1: drv(1'b0, 0, '0, '0, 1'b1, 505);
            default: drv(1'b0, 0, '0, '0, 1'b0, 0);
         endcase
      end
   endtask

   task automatic test_reset_inflight;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (ov[i] !== ev[i] || od[i] !== ed[i]) begin
               failures++;
               $display("FAIL inflight_model inst%0d valid=%b data=%h required valid=%b data=%h", i, ov[i], od[i], ev[i], ed[i]);
            end
         end
         if (c >= 2 && c <= 4) begin
            checks++;
            if (ov[0] !== 1'b0 || ov[1] !== 1'b0 || ov[2] !== 1'b0) begin
               failures++;
               $display("FAIL inflight_drop c=%0d valid=%b%b%b required=000", c, ov[0], ov[1], ov[2]);
            end
         end
         if (c == 6) begin
            checks++;
            if (od[1] !== 128'd1 || od[2] !== 128'd1) begin
               failures++;
               $display("FAIL inflight_after data=%h/%h required=1/1", od[1], od[2]);
            end
         end
         if (c == 1) reset = 1'b1;
         if (c == 3) reset = 1'b0;
         case (c)
            0, 4: drv(1'b0, 0, '0, '0, 1'b1, 1);
            1: drv(1'b0, 0, '0, '0, 1'b1, 2);
            default: drv(1'b0, 0, '0, '0, 1'b0, 0);
         endcase
      end
   endtask

   task automatic test_random;
      for (int n = 0; n < 404; n++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (ov[i] !== ev[i] || od[i] !== ed[i]) begin
               failures++;
               $display("FAIL random inst%0d n=%0d valid=%b data=%h required valid=%b data=%h", i, n, ov[i], od[i], ev[i], ed[i]);
            end
         end
         if (n < 400)
            drv(1'($urandom), ($urandom % 4 == 0) ? int'($urandom_range(511)) : int'($urandom_range(15)),
                {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 1'($urandom),
                ($urandom % 4 == 0) ? int'($urandom_range(511)) : int'($urandom_range(15)));
         else
            drv(1'b0, 0, '0, '0, 1'b0, 0);
      end
   endtask

   initial begin
      drv(1'b0, 0, '0, '0, 1'b0, 0);
      test_reset();
      test_stream();
      test_strobe();
      test_collision();
      test_oor();
      test_reset_inflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
